// File: rtl/pwm_pkg.sv
// pwm_pkg: shared magic, packet field positions, FSM states and FIFO entry layout
package pwm_pkg;

    localparam logic [15:0] PWM_MAGIC = 16'h5057;
    localparam int MAGIC_LSB = 16;
    localparam int CNT_LSB   = 8;
    localparam int CH_LSB    = 24;
    localparam int EN_BIT    = 0;
    localparam int VAL_W     = 28;

    typedef enum logic [2:0] {
        IDLE,
        ENT_CH,
        ENT_PER,
        ENT_HL,
        DROP
    } pwm_state_t;

    typedef struct packed {
        logic [7:0]       channel;
        logic             en;
        logic [VAL_W-1:0] period;
        logic [VAL_W-1:0] hlevel;
    } pwm_entry_t;

endpackage

// File: rtl/pwm_cfg_fifo.sv
// pwm_cfg_fifo: entry FIFO with speculative write pointer, commit and rewind
module pwm_cfg_fifo
    import pwm_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pwm_entry_t               push_data,
    input  logic                     commit,
    input  logic                     rewind,
    input  logic                     pop,
    output pwm_entry_t               rd_data,
    output logic                     rd_empty,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int AW = $clog2(DEPTH);

    pwm_entry_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   cm_ptr;
    logic [AW:0]   rd_ptr;

    // storage write at the speculative pointer
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // pointers: rewind drops uncommitted entries, commit publishes them to the reader
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rewind) wr_ptr <= cm_ptr;
            else if (push) wr_ptr <= wr_ptr + 1'b1;
            if (commit) cm_ptr <= wr_ptr;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign rd_empty = rd_ptr == cm_ptr;
    assign used     = wr_ptr - rd_ptr;

endmodule

// File: rtl/pwm_cfg_parser.sv
// pwm_cfg_parser: parses UDP PWM configuration packets into an all-or-nothing entry stream
module pwm_cfg_parser
    import pwm_pkg::*;
#(
    parameter logic [15:0] DST_PORT    = 16'd8080,
    parameter int          CHANNEL_NUM = 8,
    parameter int          FIFO_DEPTH  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_axis_udp_tdata,
    input  logic        rx_axis_udp_tvalid,
    input  logic        rx_axis_udp_tlast,
    input  logic [15:0] rx_axis_udp_tuser,
    output logic        cfg_vld,
    input  logic        cfg_ready,
    output logic [7:0]  cfg_channel,
    output logic        cfg_en,
    output logic [27:0] cfg_period,
    output logic [27:0] cfg_hlevel,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    pwm_state_t       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       ch_q, ch_d;
    logic             en_q, en_d;
    logic [VAL_W-1:0] per_q, per_d;
    logic             commit_q, commit_d;
    logic             push, rewind, err_inc, pop;
    pwm_entry_t       rd_data, out_q;
    logic             rd_empty;
    logic [AW:0]      used;
    logic [15:0]      hdr_magic;
    logic [7:0]       hdr_n, beat_ch;
    logic [31:0]      occ;
    logic             hdr_bad, ch_bad, last_beat;

    assign hdr_magic = rx_axis_udp_tdata[MAGIC_LSB +: 16];
    assign hdr_n     = rx_axis_udp_tdata[CNT_LSB +: 8];
    assign beat_ch   = rx_axis_udp_tdata[CH_LSB +: 8];
    assign last_beat = rx_axis_udp_tlast;
    // the output register holds one entry, so it counts against free space
    assign occ       = 32'(used) + 32'(cfg_vld);
    assign hdr_bad   = hdr_magic != PWM_MAGIC || hdr_n == 8'd0
                     || 32'(hdr_n) > 32'(FIFO_DEPTH) - occ || last_beat;
    assign ch_bad    = {1'b0, beat_ch} >= 9'(CHANNEL_NUM);
    assign pop       = !rd_empty && (!cfg_vld || cfg_ready);

    // next-state and datapath control for the packet parser
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        en_d     = en_q;
        per_d    = per_q;
        push     = 1'b0;
        rewind   = 1'b0;
        err_inc  = 1'b0;
        commit_d = 1'b0;
        if (rx_axis_udp_tvalid) begin
            case (state_q)
                IDLE: begin
                    if (rx_axis_udp_tuser != DST_PORT) begin
                        state_d = last_beat ? IDLE : DROP;
                    end else if (hdr_bad) begin
                        err_inc = 1'b1;
                        state_d = last_beat ? IDLE : DROP;
                    end else begin
                        cnt_d   = hdr_n;
                        state_d = ENT_CH;
                    end
                end
                ENT_CH: begin
                    if (ch_bad || last_beat) begin
                        err_inc = 1'b1;
                        rewind  = 1'b1;
                        state_d = last_beat ? IDLE : DROP;
                    end else begin
                        ch_d    = beat_ch;
                        en_d    = rx_axis_udp_tdata[EN_BIT];
                        state_d = ENT_PER;
                    end
                end
                ENT_PER: begin
                    if (last_beat) begin
                        err_inc = 1'b1;
                        rewind  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        per_d   = rx_axis_udp_tdata[VAL_W-1:0];
                        state_d = ENT_HL;
                    end
                end
                ENT_HL: begin
                    if ((cnt_q == 8'd1) != last_beat) begin
                        err_inc = 1'b1;
                        rewind  = 1'b1;
                        state_d = last_beat ? IDLE : DROP;
                    end else begin
                        push     = 1'b1;
                        cnt_d    = cnt_q - 8'd1;
                        commit_d = last_beat;
                        state_d  = last_beat ? IDLE : ENT_CH;
                    end
                end
                DROP: state_d = last_beat ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    // parser state and per-entry holding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            en_q     <= 1'b0;
            per_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            en_q     <= en_d;
            per_q    <= per_d;
            commit_q <= commit_d;
        end
    end

    // saturating packet and error counters; a packet counts when it commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (commit_q && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    // registered valid/ready output stage, refilled from committed entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_vld <= 1'b0;
            out_q   <= '0;
        end else if (pop) begin
            cfg_vld <= 1'b1;
            out_q   <= rd_data;
        end else if (cfg_ready) begin
            cfg_vld <= 1'b0;
        end
    end

    assign cfg_channel = out_q.channel;
    assign cfg_en      = out_q.en;
    assign cfg_period  = out_q.period;
    assign cfg_hlevel  = out_q.hlevel;

    pwm_cfg_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data('{channel: ch_q, en: en_q, period: per_q,
                     hlevel: rx_axis_udp_tdata[VAL_W-1:0]}),
        .commit   (commit_q),
        .rewind   (rewind),
        .pop      (pop),
        .rd_data  (rd_data),
        .rd_empty (rd_empty),
        .used     (used)
    );

endmodule
